// File: rtl/alu_result_pipe.sv
// Registered ALU result multiplexer: sign-extends the selected op result to N+2 bits, adds status flags,
// and passes it through a valid/ready stage with a 2-entry skid buffer. Define ALU_SAT_EN to clamp to N bits.
module alu_result_pipe #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in0,
  input  logic [N+1:0]     in1,
  input  logic [N:0]       in2,
  input  logic [N:0]       in3,
  input  logic [N-1:0]     in4,
  input  logic [N-1:0]     in5,
  input  logic [N-1:0]     in6,
  input  logic [N-1:0]     in7,
  input  logic [2:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N+1:0]     res,
  output logic [2:0]       res_op,
  output logic             res_zero,
  output logic             res_neg,
  output logic             res_sat,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int unsigned OUT_W = N + 2;

  typedef struct packed {
    logic [OUT_W-1:0] val;
    logic [2:0]       op;
    logic             zero;
    logic             neg;
    logic             sat;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  state_t           state_q, state_d;
  entry_t           or_q, or_d;
  entry_t           sk_q, sk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [OUT_W-1:0] ext;
  logic signed [OUT_W-1:0] fin;
  logic                    sat;
  entry_t                  new_e;
  logic                    accept;
  logic                    emit;

`ifdef ALU_SAT_EN
  localparam logic signed [OUT_W-1:0] SAT_MAX = OUT_W'((2 ** (N - 1)) - 1);
  localparam logic signed [OUT_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  always_comb begin
    ext = '0;
    case (sel)
      3'b000: ext = {{2{in0[N-1]}}, in0};
      3'b001: ext = in1;
      3'b010: ext = {in2[N], in2};
      3'b011: ext = {in3[N], in3};
      3'b100: ext = {{2{in4[N-1]}}, in4};
      3'b101: ext = {{2{in5[N-1]}}, in5};
      3'b110: ext = {{2{in6[N-1]}}, in6};
      3'b111: ext = {{2{in7[N-1]}}, in7};
      default: ext = '0;
    endcase
  end

  always_comb begin
    fin = ext;
    sat = 1'b0;
`ifdef ALU_SAT_EN
    if (ext > SAT_MAX) begin
      fin = SAT_MAX;
      sat = 1'b1;
    end else if (ext < SAT_MIN) begin
      fin = SAT_MIN;
      sat = 1'b1;
    end
`endif
    new_e.val  = fin;
    new_e.op   = sel;
    new_e.zero = (fin == '0);
    new_e.neg  = fin[OUT_W-1];
    new_e.sat  = sat;
  end

  // Handshake signals decode only from the state register, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sk_d    = sk_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          or_d    = new_e;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && emit) begin
          or_d = new_e;
        end else if (accept) begin
          sk_d    = new_e;
          state_d = S_TWO;
        end else if (emit) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (emit) begin
          or_d    = sk_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (emit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      or_q    <= '0;
      sk_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      or_q    <= or_d;
      sk_q    <= sk_d;
      cnt_q   <= cnt_d;
    end
  end

  assign res      = or_q.val;
  assign res_op   = or_q.op;
  assign res_zero = or_q.zero;
  assign res_neg  = or_q.neg;
  assign res_sat  = or_q.sat;
  assign xfer_cnt = cnt_q;

endmodule
